// File: rtl/m8c_issp_seq.sv
// m8c_issp_seq: command sequencer for the M8C ISSP bit engine (osc domain).
// The host queues ISSP operations. They are dispatched back-to-back to the
// bit engine through a start/busy handshake. Masked SENDVEC read-backs are
// collected in a first-word fall-through result FIFO. A per-operation
// timeout detects a hung engine.
//
// Optional build macro: ISSP_SEQ_AUTOPWROFF_EN. When it is defined, a
// timeout first issues a PWROFF operation to the engine and then enters
// ERROR. When it is undefined, a timeout goes directly to ERROR.
//
// Ports:
//   osc, rst_n                    clock; synchronous active-low reset
//   q_wr, q_cmd, q_vec, q_mask    command queue push
//   q_full, q_level               command queue status
//   run, clr_err                  dispatch enable; clear errors / leave ERROR
//   eng_start, eng_cmd,
//   eng_vec, eng_mask             engine request (held until the next pop)
//   eng_busy, eng_invec           engine status and read-back vector
//   res_rd, res_data, res_empty   result FIFO pop, head and status
//   seq_idle                      IDLE state with an empty queue
//   err_timeout, err_overflow     sticky error flags
`timescale 1ns/1ps
module m8c_issp_seq #(
  parameter int unsigned QDEPTH_LOG2 = 3,
  parameter int unsigned RDEPTH_LOG2 = 2,
  parameter int unsigned TIMEOUT     = 24000
) (
  input  logic                   osc,
  input  logic                   rst_n,
  input  logic                   q_wr,
  input  logic [2:0]             q_cmd,
  input  logic [21:0]            q_vec,
  input  logic [21:0]            q_mask,
  output logic                   q_full,
  output logic [QDEPTH_LOG2:0]   q_level,
  input  logic                   run,
  input  logic                   clr_err,
  output logic                   eng_start,
  output logic [7:0]             eng_cmd,
  output logic [21:0]            eng_vec,
  output logic [21:0]            eng_mask,
  input  logic                   eng_busy,
  input  logic [21:0]            eng_invec,
  input  logic                   res_rd,
  output logic [21:0]            res_data,
  output logic                   res_empty,
  output logic                   seq_idle,
  output logic                   err_timeout,
  output logic                   err_overflow
);

  localparam int unsigned QPW    = QDEPTH_LOG2;
  localparam int unsigned QLW    = QDEPTH_LOG2 + 1;
  localparam int unsigned QDEPTH = 1 << QDEPTH_LOG2;
  localparam int unsigned RPW    = RDEPTH_LOG2;
  localparam int unsigned RLW    = RDEPTH_LOG2 + 1;
  localparam int unsigned RDEPTH = 1 << RDEPTH_LOG2;
  localparam int unsigned TW     = $clog2(TIMEOUT);

  localparam logic [2:0] CMD_POR     = 3'd1;
  localparam logic [2:0] CMD_PWROFF  = 3'd2;
  localparam logic [2:0] CMD_SENDVEC = 3'd3;
  localparam logic [2:0] CMD_EXEC    = 3'd4;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [21:0] vec;
    logic [21:0] mask;
  } cmd_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_STORE,
    S_ERROR,
    S_PWROFF_ISSUE,
    S_PWROFF_WAIT
  } state_t;

`ifdef ISSP_SEQ_AUTOPWROFF_EN
  localparam state_t S_TOUT_NEXT = S_PWROFF_ISSUE;
`else
  localparam state_t S_TOUT_NEXT = S_ERROR;
`endif

  // Storage and state registers
  cmd_entry_t          r_qmem [QDEPTH];
  logic [QPW-1:0]      r_qwr, r_qrd;
  logic [QLW-1:0]      r_qlevel;
  logic [21:0]         r_rmem [RDEPTH];
  logic [RPW-1:0]      r_rwr, r_rrd;
  logic [RLW-1:0]      r_rlevel;
  state_t              r_state;
  logic [TW-1:0]       r_tcnt;
  logic                r_eng_start;
  logic [7:0]          r_eng_cmd;
  logic [21:0]         r_eng_vec, r_eng_mask;
  logic                r_q_full, r_res_empty, r_seq_idle;
  logic                r_err_tout, r_err_ovf;

  // Next-state / control wires
  state_t              w_state_nxt;
  cmd_entry_t          w_head;
  logic                w_cmd_valid, w_tout, w_q_empty, w_r_full;
  logic                w_q_push, w_q_pop, w_q_flush, w_q_ovf;
  logic                w_r_push, w_r_pop;
  logic                w_load, w_pwroff, w_tcnt_clr, w_tcnt_inc, w_set_tout;
  logic [QLW-1:0]      w_qlevel_nxt;
  logic [RLW-1:0]      w_rlevel_nxt;

  assign w_head      = r_qmem[r_qrd];
  assign w_cmd_valid = (w_head.cmd == CMD_POR) || (w_head.cmd == CMD_PWROFF) ||
                       (w_head.cmd == CMD_SENDVEC) || (w_head.cmd == CMD_EXEC);
  // The counter reaches TIMEOUT-1 on the same edge that flags the timeout.
  assign w_tout      = (r_tcnt == TW'(TIMEOUT - 2));
  assign w_q_empty   = (r_qlevel == '0);
  assign w_r_full    = (r_rlevel == RLW'(RDEPTH));
  assign w_q_push    = q_wr && !r_q_full && !w_q_flush;
  assign w_q_ovf     = q_wr && r_q_full;
  assign w_r_pop     = res_rd && (r_rlevel != '0);

  // FSM next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_q_pop     = 1'b0;
    w_q_flush   = 1'b0;
    w_r_push    = 1'b0;
    w_load      = 1'b0;
    w_pwroff    = 1'b0;
    w_tcnt_clr  = 1'b0;
    w_tcnt_inc  = 1'b0;
    w_set_tout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run && !w_q_empty) begin
          // Invalid codes are popped and dropped without a start pulse.
          w_q_pop = 1'b1;
          if (w_cmd_valid) begin
            w_load      = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_tcnt_clr  = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        w_tcnt_inc = 1'b1;
        if (eng_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (w_tout) begin
          w_set_tout  = 1'b1;
          w_state_nxt = S_TOUT_NEXT;
        end
      end
      S_WAIT_DONE: begin
        w_tcnt_inc = 1'b1;
        if (!eng_busy) begin
          if ((r_eng_cmd == 8'(CMD_SENDVEC)) && (r_eng_mask != '0))
            w_state_nxt = S_STORE;
          else
            w_state_nxt = S_IDLE;
        end else if (w_tout) begin
          w_set_tout  = 1'b1;
          w_state_nxt = S_TOUT_NEXT;
        end
      end
      S_STORE: begin
        // A pop in the same cycle frees the slot even when the FIFO is full.
        if (!w_r_full || w_r_pop) begin
          w_r_push    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ERROR: begin
        if (clr_err) begin
          w_q_flush   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`ifdef ISSP_SEQ_AUTOPWROFF_EN
      S_PWROFF_ISSUE: begin
        w_tcnt_clr  = 1'b1;
        w_state_nxt = S_PWROFF_WAIT;
      end
      S_PWROFF_WAIT: begin
        w_tcnt_inc = 1'b1;
        if (!eng_busy || w_tout)
          w_state_nxt = S_ERROR;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef ISSP_SEQ_AUTOPWROFF_EN
    if (w_set_tout)
      w_pwroff = 1'b1;
`endif
  end

  // Occupancy next values
  always_comb begin
    w_qlevel_nxt = r_qlevel;
    if (w_q_flush)
      w_qlevel_nxt = '0;
    else if (w_q_push && !w_q_pop)
      w_qlevel_nxt = r_qlevel + QLW'(1);
    else if (w_q_pop && !w_q_push)
      w_qlevel_nxt = r_qlevel - QLW'(1);

    w_rlevel_nxt = r_rlevel;
    if (w_r_push && !w_r_pop)
      w_rlevel_nxt = r_rlevel + RLW'(1);
    else if (w_r_pop && !w_r_push)
      w_rlevel_nxt = r_rlevel - RLW'(1);
  end

  // State, pointers, counters and registered outputs
  always_ff @(posedge osc) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_qwr       <= '0;
      r_qrd       <= '0;
      r_qlevel    <= '0;
      r_rwr       <= '0;
      r_rrd       <= '0;
      r_rlevel    <= '0;
      r_tcnt      <= '0;
      r_eng_start <= 1'b0;
      r_eng_cmd   <= '0;
      r_eng_vec   <= '0;
      r_eng_mask  <= '0;
      r_q_full    <= 1'b0;
      r_res_empty <= 1'b1;
      r_seq_idle  <= 1'b1;
      r_err_tout  <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_q_flush) begin
        r_qrd <= r_qwr;
      end else begin
        if (w_q_push) r_qwr <= r_qwr + QPW'(1);
        if (w_q_pop)  r_qrd <= r_qrd + QPW'(1);
      end
      r_qlevel <= w_qlevel_nxt;

      if (w_r_push) r_rwr <= r_rwr + RPW'(1);
      if (w_r_pop)  r_rrd <= r_rrd + RPW'(1);
      r_rlevel <= w_rlevel_nxt;

      if (w_tcnt_clr)
        r_tcnt <= '0;
      else if (w_tcnt_inc)
        r_tcnt <= r_tcnt + TW'(1);

      r_eng_start <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_PWROFF_ISSUE);
      if (w_load) begin
        r_eng_cmd  <= 8'(w_head.cmd);
        r_eng_vec  <= w_head.vec;
        r_eng_mask <= w_head.mask;
      end else if (w_pwroff) begin
        r_eng_cmd  <= 8'(CMD_PWROFF);
      end

      r_q_full    <= (w_qlevel_nxt == QLW'(QDEPTH));
      r_res_empty <= (w_rlevel_nxt == '0);
      r_seq_idle  <= (w_state_nxt == S_IDLE) && (w_qlevel_nxt == '0);

      if (w_set_tout)   r_err_tout <= 1'b1;
      else if (clr_err) r_err_tout <= 1'b0;
      if (w_q_ovf)      r_err_ovf  <= 1'b1;
      else if (clr_err) r_err_ovf  <= 1'b0;
    end
  end

  // FIFO storage arrays (contents need no reset)
  always_ff @(posedge osc) begin
    if (w_q_push) r_qmem[r_qwr] <= '{cmd: q_cmd, vec: q_vec, mask: q_mask};
    if (w_r_push) r_rmem[r_rwr] <= eng_invec;
  end

  assign q_full       = r_q_full;
  assign q_level      = r_qlevel;
  assign eng_start    = r_eng_start;
  assign eng_cmd      = r_eng_cmd;
  assign eng_vec      = r_eng_vec;
  assign eng_mask     = r_eng_mask;
  assign res_data     = r_res_empty ? '0 : r_rmem[r_rrd];
  assign res_empty    = r_res_empty;
  assign seq_idle     = r_seq_idle;
  assign err_timeout  = r_err_tout;
  assign err_overflow = r_err_ovf;

endmodule
